// File: rtl/hline_zbuff_ctrl.sv
// Horizontal-line z-buffer controller: reads a z row in bursts, interpolates and depth-tests z,
// then writes z and framebuffer bursts. Optional macro HLINE_ZSKIP_EN skips all-fail chunks.
module hline_zbuff_ctrl #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned X_W       = 16,
  parameter int unsigned Z_W       = 32,
  parameter int unsigned MAX_BURST = 256,
  parameter int unsigned BPP       = 4,
  parameter int unsigned ZFUNC     = 0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_fb_row_addr,
  input  logic [ADDR_W-1:0] i_zb_row_addr,
  input  logic [X_W-1:0]    i_x1,
  input  logic [X_W-1:0]    i_x2,
  input  logic [Z_W-1:0]    i_z_start,
  input  logic [Z_W-1:0]    i_slope,
  input  logic [X_W-1:0]    i_rem,
  input  logic [X_W-1:0]    i_dx,
  input  logic              i_axi_done,
  input  logic              i_zin_empty,
  input  logic [Z_W-1:0]    i_zin_data,
  output logic              o_rd_req,
  output logic              o_wr_req,
  output logic [ADDR_W-1:0] o_addr,
  output logic [8:0]        o_burst_len,
  output logic              o_wr_sel,
  output logic              o_zin_rd,
  output logic              o_zout_wr,
  output logic [Z_W-1:0]    o_zout_data,
  output logic              o_be_data,
  output logic              o_busy,
`ifdef HLINE_ZSKIP_EN
  output logic              o_flush,
`endif
  output logic              o_done
);

  localparam int unsigned LW = X_W + 1;

  typedef enum logic [2:0] {StIdle, StRd, StInterp, StWrZ, StWrFb, StFinish} state_e;

  state_e            r_state;
  logic [ADDR_W-1:0] r_fb_row, r_zb_row, r_offset, r_addr;
  logic [Z_W-1:0]    r_slope, r_zacc;
  logic [X_W-1:0]    r_rem, r_dx;
  logic [LW-1:0]     r_remain, r_err;
  logic [8:0]        r_cnt, r_burst_len;
  logic              r_rd_req, r_wr_req, r_wr_sel, r_busy, r_done;
`ifdef HLINE_ZSKIP_EN
  logic              r_any_pass, r_flush;
`endif

  logic [X_W-1:0]    w_xs, w_xe;
  logic [LW-1:0]     w_len, w_remain_nxt, w_rd_remain, w_err_sum, w_err_nxt;
  logic [ADDR_W-1:0] w_off0, w_off_nxt;
  logic [8:0]        w_rd_blen;
  logic [Z_W-1:0]    w_zstep, w_zacc_nxt;
  logic              w_pop, w_pass, w_carry, w_skip, w_last, w_complete;

  always_comb begin
    w_xs         = (i_x1 < i_x2) ? i_x1 : i_x2;
    w_xe         = (i_x1 < i_x2) ? i_x2 : i_x1;
    w_len        = {1'b0, w_xe - w_xs} + LW'(1);
    w_off0       = ADDR_W'(w_xs) * ADDR_W'(BPP);
    w_remain_nxt = r_remain - LW'(r_burst_len);
    w_off_nxt    = r_offset + ADDR_W'(r_burst_len) * ADDR_W'(BPP);
    // The next RD burst is sized either from a fresh line or from what is left after this chunk
    w_rd_remain  = (r_state == StIdle) ? w_len : w_remain_nxt;
    w_rd_blen    = (w_rd_remain > LW'(MAX_BURST)) ? 9'(MAX_BURST) : 9'(w_rd_remain);
  end

  always_comb begin
    if (ZFUNC == 0)      w_pass = r_zacc < i_zin_data;
    else if (ZFUNC == 1) w_pass = r_zacc <= i_zin_data;
    else                 w_pass = 1'b1;
  end

  always_comb begin
    w_pop      = (r_state == StInterp) && !i_zin_empty;
    w_last     = (r_cnt == 9'd1);
    w_err_sum  = r_err + {1'b0, r_rem};
    w_carry    = w_err_sum >= {1'b0, r_dx};
    // Fraction overflow steps one extra unit away from zero in the slope's direction
    w_zstep    = r_slope + (r_slope[Z_W-1] ? {Z_W{1'b1}} : Z_W'(1));
    w_zacc_nxt = r_zacc + (w_carry ? w_zstep : r_slope);
    w_err_nxt  = w_carry ? (w_err_sum - {1'b0, r_dx}) : w_err_sum;
  end

`ifdef HLINE_ZSKIP_EN
  assign w_skip = ~(r_any_pass | w_pass);
`else
  assign w_skip = 1'b0;
`endif

  assign w_complete = ((r_state == StWrFb) && i_axi_done) || (w_pop && w_last && w_skip);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_fb_row    <= '0;
      r_zb_row    <= '0;
      r_offset    <= '0;
      r_addr      <= '0;
      r_slope     <= '0;
      r_zacc      <= '0;
      r_rem       <= '0;
      r_dx        <= '0;
      r_remain    <= '0;
      r_err       <= '0;
      r_cnt       <= '0;
      r_burst_len <= '0;
      r_rd_req    <= 1'b0;
      r_wr_req    <= 1'b0;
      r_wr_sel    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef HLINE_ZSKIP_EN
      r_any_pass  <= 1'b0;
      r_flush     <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef HLINE_ZSKIP_EN
      r_flush <= 1'b0;
`endif
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_fb_row    <= i_fb_row_addr;
            r_zb_row    <= i_zb_row_addr;
            r_slope     <= i_slope;
            r_rem       <= i_rem;
            r_dx        <= i_dx;
            r_remain    <= w_len;
            r_offset    <= w_off0;
            r_zacc      <= i_z_start;
            r_err       <= '0;
            r_burst_len <= w_rd_blen;
            r_addr      <= i_zb_row_addr + w_off0;
            r_rd_req    <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= StRd;
          end
        end
        StRd: begin
          if (i_axi_done) begin
            r_rd_req <= 1'b0;
            r_cnt    <= r_burst_len;
`ifdef HLINE_ZSKIP_EN
            r_any_pass <= 1'b0;
`endif
            r_state  <= StInterp;
          end
        end
        StInterp: begin
          if (w_pop) begin
            r_zacc <= w_zacc_nxt;
            r_err  <= w_err_nxt;
            r_cnt  <= r_cnt - 9'd1;
`ifdef HLINE_ZSKIP_EN
            r_any_pass <= r_any_pass | w_pass;
            if (w_last && w_skip) r_flush <= 1'b1;
`endif
            if (w_last && !w_skip) begin
              r_wr_req <= 1'b1;
              r_wr_sel <= 1'b0;
              r_addr   <= r_zb_row + r_offset;
              r_state  <= StWrZ;
            end
          end
        end
        StWrZ: begin
          if (i_axi_done) begin
            r_wr_sel <= 1'b1;
            r_addr   <= r_fb_row + r_offset;
            r_state  <= StWrFb;
          end
        end
        StWrFb: ;
        StFinish: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase

      if (w_complete) begin
        r_remain <= w_remain_nxt;
        r_offset <= w_off_nxt;
        r_wr_req <= 1'b0;
        r_wr_sel <= 1'b0;
        if (w_remain_nxt == '0) begin
          r_done  <= 1'b1;
          r_state <= StFinish;
        end else begin
          r_rd_req    <= 1'b1;
          r_burst_len <= w_rd_blen;
          r_addr      <= r_zb_row + w_off_nxt;
          r_state     <= StRd;
        end
      end
    end
  end

  assign o_rd_req    = r_rd_req;
  assign o_wr_req    = r_wr_req;
  assign o_addr      = r_addr;
  assign o_burst_len = r_burst_len;
  assign o_wr_sel    = r_wr_sel;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_zin_rd    = w_pop;
  assign o_zout_wr   = w_pop;
  assign o_zout_data = w_pop ? (w_pass ? r_zacc : i_zin_data) : '0;
  assign o_be_data   = w_pop & w_pass;
`ifdef HLINE_ZSKIP_EN
  assign o_flush     = r_flush;
`endif

endmodule

// File: doc/hline_zbuff_ctrl.md
Name: hline_zbuff_ctrl

Overview:
Parametrised horizontal-line z-buffer controller for the hline_zbuff pcore.
- Per line: reads the z-buffer row in bursts of up to MAX_BURST pixels and interpolates z per pixel (integer slope plus error-term fraction).
- Depth-tests each pixel and streams new z values plus per-pixel byte-enables into FIFOs.
- Issues burst writes to the z-buffer, then to the framebuffer.
- Sits between the register slave (line parameters) and the AXI burst master (rd_req/wr_req/axi_done).

Parameters:
ADDR_W, 32, address width
X_W, 16, x coordinate width
Z_W, 32, z value width (unsigned depth)
MAX_BURST, 256, max pixels per burst (power of two, 2..256)
BPP, 4, bytes per pixel in both buffers
ZFUNC, 0, depth test: 0 = new<old passes, 1 = new<=old, 2 = always pass

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; ignored unless idle
fb_row_addr  in  ADDR_W  byte address of framebuffer row (x=0)
zb_row_addr  in  ADDR_W  byte address of z-buffer row (x=0)
x1, x2  in  X_W  endpoints, either order
z_start  in  Z_W  z at min(x1,x2)
slope  in  Z_W  signed integer z step per pixel, left to right
rem  in  X_W  fractional step numerator
dx  in  X_W  fractional denominator (>0 when rem>0)
axi_done  in  1  one-cycle pulse: current burst complete
zin_empty  in  1  z read FIFO empty
zin_data  in  Z_W  z read FIFO head
rd_req, wr_req  out  1  burst request, held until axi_done
addr  out  ADDR_W  burst byte address
burst_len  out  9  pixels in current burst (1..MAX_BURST)
wr_sel  out  1  0 = z-buffer write, 1 = framebuffer write
zin_rd  out  1  pop z read FIFO
zout_wr  out  1  push zout_data/be_data
zout_data  out  Z_W  z to write (new if passed, else old)
be_data  out  1  1 = pixel passed depth test
busy, done  out  1  busy while not IDLE; done = one-cycle pulse at line end

Behaviour:
- Reset (async): state IDLE; all outputs 0; counters, z, error = 0.
- Totals: len = |x2-x1|+1 (x1==x2 gives 1 pixel); xs = min(x1,x2); offset = xs*BPP.
- States: IDLE, RD, INTERP, WR_Z, WR_FB, FINISH.
- IDLE: on start, latch all inputs, remain=len, zacc=z_start, err=0 -> RD.
- RD: burst_len = min(remain, MAX_BURST); addr = zb_row_addr+offset; rd_req=1. On axi_done -> INTERP with cnt=burst_len.
- INTERP: each cycle with !zin_empty: zin_rd=zout_wr=1 (combinational, same cycle); compare zacc vs zin_data per ZFUNC.
  - Pass: be=1, zout=zacc. Fail: be=0, zout=zin_data.
  - Then err += rem; if err >= dx: zacc += slope + (slope[Z_W-1] ? -1 : +1) and err -= dx; else zacc += slope.
  - Arithmetic wraps modulo 2^Z_W; err is X_W+1 bits.
  - Stall with no outputs while zin_empty.
  - Last pixel (cnt==1) -> WR_Z.
- WR_Z: wr_req=1, wr_sel=0, addr = zb_row_addr+offset. On axi_done -> WR_FB.
- WR_FB: wr_req=1, wr_sel=1, addr = fb_row_addr+offset. On axi_done: remain -= burst_len; offset += burst_len*BPP; remain==0 -> FINISH, else -> RD.
- FINISH: done=1 for one cycle -> IDLE.
- addr, burst_len, wr_sel are stable for the whole request.
- axi_done outside RD/WR_Z/WR_FB is ignored. start while busy is ignored.
- Reset asserted mid-line aborts immediately; no done pulse.
- zacc and err carry across bursts, so interpolation is continuous over chunk boundaries.

Optional Feature:
HLINE_ZSKIP_EN
- Defined: count passes per burst; if zero at the end of INTERP, skip WR_Z/WR_FB and do the WR_FB-completion update (remain, offset) directly, then go to RD or FINISH. The FIFO contents of that chunk are flushed by a one-cycle flush output pulse (extra port, present only with the macro).
- Undefined: both writes always issued; no flush port.

Test Plan:
- x1=13, x2=10, z_start=100, slope=5, rem=0, zin all 1000 -> one read burst_len=4 at zb_row_addr+40; zout 100,105,110,115, be all 1; writes at zb+40 then fb+40; done pulse.
- x1=0, x2=299, MAX_BURST=256 -> bursts len 256 at offset 0 and len 44 at offset 1024; each gets rd, wr(z), wr(fb); z continuous across the boundary.
- slope=0, rem=1, dx=3, z_start=0, 4 pixels -> zout 0,0,0,1.
- ZFUNC=0, zin=zacc=50 -> be=0, zout=50; ZFUNC=1, same stimulus -> be=1.
- zin_empty toggled every other cycle in INTERP -> zin_rd/zout_wr only when non-empty, sequence unchanged; HLINE_ZSKIP_EN with all fails -> no wr_req, flush pulse, done.
- reset raised during WR_Z -> same-cycle outputs 0, state IDLE, no done; next start runs normally.
